// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, direction bits and geometry helpers
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic DIR_RIGHT  = 1'b0;
    localparam logic DIR_LEFT   = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;
    localparam logic DIR_UP     = 1'b1;
    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    function automatic int left_face(input int pad_margin, input int pad_w);
        return pad_margin + pad_w;
    endfunction

    function automatic int right_face(input int h_res, input int pad_margin, input int pad_w);
        return h_res - pad_margin - pad_w;
    endfunction

    // Top/left coordinate that centres an object of 'size' within 'extent'.
    function automatic int centre(input int extent, input int size);
        return (extent - size) / 2;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop synchroniser for one asynchronous button
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pong_core.sv
// rtl/pong_core.sv - frame-locked pong engine: paddles, ball, scoring and serve/win FSM
module pong_core
    import pong_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int POS_W        = 10,
    parameter int PAD_H        = 64,
    parameter int PAD_W        = 8,
    parameter int PAD_MARGIN   = 16,
    parameter int BALL_SIZE    = 8,
    parameter int PAD_STEP     = 4,
    parameter int BALL_STEP    = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               l_up,
    input  logic               l_down,
    input  logic               r_up,
    input  logic               r_down,
    input  logic               serve,
    output logic [POS_W-1:0]   l_pos,
    output logic [POS_W-1:0]   r_pos,
    output logic [POS_W-1:0]   x_ball_pos,
    output logic [POS_W-1:0]   y_ball_pos,
    output logic [SCORE_W-1:0] l_score,
    output logic [SCORE_W-1:0] r_score,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         game_state
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    // One extra bit so that position sums never wrap before comparison.
    typedef logic [POS_W:0]     arith_t;
    typedef logic [POS_W-1:0]   pos_t;
    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    localparam arith_t LF        = arith_t'(left_face(PAD_MARGIN, PAD_W));
    localparam arith_t RF        = arith_t'(right_face(H_RES, PAD_MARGIN, PAD_W));
    localparam arith_t X_CTR     = arith_t'(centre(H_RES, BALL_SIZE));
    localparam arith_t Y_CTR     = arith_t'(centre(V_RES, BALL_SIZE));
    localparam arith_t PAD_CTR   = arith_t'(centre(V_RES, PAD_H));
    localparam arith_t PAD_MAX   = arith_t'(V_RES - PAD_H);
    localparam arith_t BALL_YMAX = arith_t'(V_RES - BALL_SIZE);
    localparam arith_t HRES      = arith_t'(H_RES);
    localparam arith_t PSTEP     = arith_t'(PAD_STEP);
    localparam arith_t BSTEP     = arith_t'(BALL_STEP);
    localparam arith_t BSIZE     = arith_t'(BALL_SIZE);
    localparam arith_t PADH      = arith_t'(PAD_H);
    localparam arith_t R_SNAP    = RF - BSIZE;
    localparam arith_t R_WIN_LO  = RF - BSIZE - BSTEP;
    localparam arith_t L_WIN_HI  = LF + BSTEP;
    localparam score_t WIN       = score_t'(WIN_SCORE);
    localparam cnt_t   CNT_LAST  = cnt_t'(SERVE_FRAMES - 1);

    logic [4:0] btn_raw;
    logic [4:0] btn_s;
    logic       l_up_s, l_down_s, r_up_s, r_down_s, serve_s;

    assign btn_raw = {serve, r_down, r_up, l_down, l_up};
    assign {serve_s, r_down_s, r_up_s, l_down_s, l_up_s} = btn_s;

    for (genvar g = 0; g < 5; g++) begin : g_sync
        btn_sync u_sync (
            .clk  (clk),
            .rst_n(reset),
            .d_i  (btn_raw[g]),
            .q_o  (btn_s[g])
        );
    end

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    pos_t   l_pos_q, l_pos_d, r_pos_q, r_pos_d;
    pos_t   x_q, x_d, y_q, y_d;
    logic   dx_q, dx_d, dy_q, dy_d;
    score_t l_score_q, l_score_d, r_score_q, r_score_d;
    logic   game_over_q, game_over_d;
    logic   winner_q, winner_d;
    logic   scorer_q, scorer_d;
    score_t new_score;

    arith_t xa, ya, lpa, rpa;
    assign xa  = arith_t'(x_q);
    assign ya  = arith_t'(y_q);
    assign lpa = arith_t'(l_pos_q);
    assign rpa = arith_t'(r_pos_q);

    function automatic pos_t paddle_next(input arith_t pos, input logic up, input logic dn);
        if (up && !dn) begin
            return (pos >= PSTEP) ? pos_t'(pos - PSTEP) : '0;
        end else if (dn && !up) begin
            return (pos + PSTEP > PAD_MAX) ? pos_t'(PAD_MAX) : pos_t'(pos + PSTEP);
        end
        return pos_t'(pos);
    endfunction

    function automatic logic overlap(input arith_t y, input arith_t pad);
        return (y + BSIZE > pad) && (y < pad + PADH);
    endfunction

    function automatic score_t sat_inc(input score_t s);
        return (s >= WIN) ? WIN : s + score_t'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_pos_d     = l_pos_q;
        r_pos_d     = r_pos_q;
        x_d         = x_q;
        y_d         = y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        l_score_d   = l_score_q;
        r_score_d   = r_score_q;
        winner_d    = winner_q;
        scorer_d    = scorer_q;
        new_score   = '0;

        case (state_q)
            ST_IDLE: begin
                if (serve_s) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_LAST) state_d = ST_PLAY;
                    else                   cnt_d   = cnt_q + cnt_t'(1);
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (dy_q == DIR_DOWN) begin
                        if (ya + BSTEP >= BALL_YMAX) begin
                            y_d  = pos_t'(BALL_YMAX);
                            dy_d = DIR_UP;
                        end else begin
                            y_d  = pos_t'(ya + BSTEP);
                        end
                    end else if (ya <= BSTEP) begin
                        y_d  = '0;
                        dy_d = DIR_DOWN;
                    end else begin
                        y_d  = pos_t'(ya - BSTEP);
                    end

                    // Only the face the ball is travelling toward can be hit or missed.
                    if (dx_q == DIR_RIGHT) begin
                        if (xa >= R_WIN_LO && xa <= R_SNAP && overlap(ya, rpa)) begin
                            x_d  = pos_t'(R_SNAP);
                            dx_d = DIR_LEFT;
                        end else if (xa + BSIZE + BSTEP > HRES) begin
                            state_d  = ST_POINT;
                            scorer_d = SIDE_LEFT;
                        end else begin
                            x_d  = pos_t'(xa + BSTEP);
                        end
                    end else begin
                        if (xa >= LF && xa <= L_WIN_HI && overlap(ya, lpa)) begin
                            x_d  = pos_t'(LF);
                            dx_d = DIR_RIGHT;
                        end else if (xa < BSTEP) begin
                            state_d  = ST_POINT;
                            scorer_d = SIDE_RIGHT;
                        end else begin
                            x_d  = pos_t'(xa - BSTEP);
                        end
                    end
                end
            end
            ST_POINT: begin
                new_score = sat_inc((scorer_q == SIDE_LEFT) ? l_score_q : r_score_q);
                if (scorer_q == SIDE_LEFT) l_score_d = new_score;
                else                       r_score_d = new_score;
                if (new_score == WIN) begin
                    state_d  = ST_OVER;
                    winner_d = scorer_q;
                end else begin
                    state_d = ST_SERVE;
                    dx_d    = (scorer_q == SIDE_LEFT) ? DIR_RIGHT : DIR_LEFT;
                    dy_d    = ~dy_q;
                end
            end
            ST_OVER: begin
                if (serve_s) begin
                    state_d   = ST_IDLE;
                    l_score_d = '0;
                    r_score_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_tick && (state_q == ST_IDLE || state_q == ST_SERVE || state_q == ST_PLAY)) begin
            l_pos_d = paddle_next(lpa, l_up_s, l_down_s);
            r_pos_d = paddle_next(rpa, r_up_s, r_down_s);
        end

        if (state_q != ST_SERVE) cnt_d = '0;

        if (state_d == ST_SERVE) begin
            x_d = pos_t'(X_CTR);
            y_d = pos_t'(Y_CTR);
        end

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            l_pos_q     <= pos_t'(PAD_CTR);
            r_pos_q     <= pos_t'(PAD_CTR);
            x_q         <= pos_t'(X_CTR);
            y_q         <= pos_t'(Y_CTR);
            dx_q        <= DIR_RIGHT;
            dy_q        <= DIR_DOWN;
            l_score_q   <= '0;
            r_score_q   <= '0;
            game_over_q <= 1'b0;
            winner_q    <= SIDE_LEFT;
            scorer_q    <= SIDE_LEFT;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_pos_q     <= l_pos_d;
            r_pos_q     <= r_pos_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            l_score_q   <= l_score_d;
            r_score_q   <= r_score_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            scorer_q    <= scorer_d;
        end
    end

    assign l_pos      = l_pos_q;
    assign r_pos      = r_pos_q;
    assign x_ball_pos = x_q;
    assign y_ball_pos = y_q;
    assign l_score    = l_score_q;
    assign r_score    = r_score_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign game_state = state_q;

endmodule

// File: doc/pong_core.md
# pong_core

Parametrised game engine that generalises the existing paddle/ball logic: configurable screen geometry, paddle and ball sizes, and speeds, plus scoring, a serve/win state machine and frame-locked motion. It sits between the player button inputs and the VGA renderer. It consumes a once-per-frame `frame_tick` from the VGA timing block and drives paddle, ball and score registers that the renderer reads.

## Interface
- `H_RES`, 640: visible width in pixels.
- `V_RES`, 480: visible height in pixels.
- `POS_W`, 10: width of every position port.
- `PAD_H`, 64 / `PAD_W`, 8: paddle height and width.
- `PAD_MARGIN`, 16: gap between the screen edge and a paddle's outer edge.
- `BALL_SIZE`, 8: the ball is a square with this side length.
- `PAD_STEP`, 4 / `BALL_STEP`, 2: pixels moved per frame tick.
- `SERVE_FRAMES`, 60: frame ticks spent in SERVE before play starts.
- `SCORE_W`, 4 / `WIN_SCORE`, 9: score counter width and the winning score.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per frame, already synchronous to `clk`.
- `l_up`, `l_down`, `r_up`, `r_down`, `serve`  in  1 each  raw asynchronous buttons, active-high.
- `l_pos`, `r_pos`  out  POS_W  top y coordinate of each paddle.
- `x_ball_pos`, `y_ball_pos`  out  POS_W  top-left corner of the ball.
- `l_score`, `r_score`  out  SCORE_W  current scores.
- `game_over`  out  1  high while in OVER.
- `winner`  out  1  0 = left, 1 = right; valid only while `game_over` is high.
- `game_state`  out  3  encoded FSM state, for debug and rendering.

## Operation
- **Input synchronisation.** All five buttons pass through a 2-FF synchroniser. Logic only ever uses the synchronised levels.
- **Derived constants.**
  - `LF = PAD_MARGIN+PAD_W = 24`: left paddle face.
  - `RF = H_RES-PAD_MARGIN-PAD_W = 616`: right paddle face.
  - Ball centre is x = 316, y = 236. Paddle centre is y = 208.
- **Reset values.**
  - Paddles at 208; ball at (316, 236).
  - Direction bits: dx = right, dy = down.
  - Scores 0, `game_over` = 0, `winner` = 0, state IDLE.
- **FSM states:** IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
  - **IDLE:** `serve` high → enter SERVE and clear the frame counter.
  - **SERVE:** counts frame ticks. On the SERVE_FRAMES-th tick → PLAY. The ball is held at centre.
  - **PLAY:** the ball moves on each frame tick. A miss → POINT.
  - **POINT:** lasts exactly one clk cycle.
    - The scorer's score increments, saturating at WIN_SCORE.
    - If the new score equals WIN_SCORE → OVER and `winner` is latched.
    - Otherwise → SERVE. The ball is recentred, dx points toward the player who conceded, and dy toggles.
  - **OVER:** ball and paddles are frozen. `serve` high → clear scores and go to IDLE. If `serve` is still high, IDLE then passes to SERVE on the following cycle.
- **Paddles.** Updated on frame ticks in IDLE, SERVE and PLAY only.
  - Up-only: `pos = pos >= PAD_STEP ? pos-PAD_STEP : 0`.
  - Down-only: `pos = min(pos+PAD_STEP, V_RES-PAD_H)`.
  - Both pressed or neither pressed: hold.
- **Ball, vertical axis** (PLAY frame tick):
  - Moving down and `y+BALL_STEP >= V_RES-BALL_SIZE` → y = 472, dy flips to up.
  - Moving up and `y <= BALL_STEP` → y = 0, dy flips to down.
  - Otherwise y moves by ±BALL_STEP.
- **Ball, horizontal axis** (PLAY frame tick):
  - A hit test applies only while crossing a face. Left: `LF <= x <= LF+BALL_STEP`. Right: `RF-BALL_SIZE-BALL_STEP <= x <= RF-BALL_SIZE`.
  - Overlap means `y+BALL_SIZE > pad_pos && y < pad_pos+PAD_H`, using the paddle value registered before this tick.
  - Hit → x snaps to the face (24, or 608 on the right) and dx flips.
  - Miss, left side: `x < BALL_STEP` → POINT for the right player.
  - Miss, right side: `x+BALL_SIZE+BALL_STEP > H_RES` → POINT for the left player.
  - Otherwise x moves by ±BALL_STEP.
  - Both axes update on the same tick.
- **Arithmetic width.** All comparisons use POS_W+1 bits so that sums cannot wrap.

## Timing
- All outputs are registered. A frame tick sampled high in cycle n is reflected on the outputs in cycle n+1.
- Button-to-effect latency is 2 clk cycles of synchronisation, plus the wait for the next `frame_tick`.
- No position changes at all without `frame_tick`.
- `frame_tick` arriving in the POINT cycle is ignored.
- Asserting `reset` at any time, including mid-PLAY, immediately forces all reset values. There is no clock dependence on assertion. Deassertion is synchronised by the system.

## Structure
- **`pong_pkg`:**
  - State enum and its 3-bit encoding.
  - Direction-bit encoding.
  - Functions deriving LF, RF and the centre coordinates from the parameters.
- **`btn_sync`:** one sub-module, a 2-FF synchroniser with async active-low reset. It is instantiated five times.
- FSM, paddle logic and ball logic stay in `pong_core`.

## Test plan
- **Reset:** assert `reset` low → `l_pos` = `r_pos` = 208, ball (316, 236), scores 0, `game_state` = 0, `game_over` = 0.
- **Paddle travel:** hold `l_up` for 60 frame ticks → `l_pos` reaches 0 after 52 ticks and stays at 0. Press `r_up` and `r_down` together → `r_pos` holds.
- **Serve:** pulse `serve` → exactly 60 ticks in SERVE, then the ball moves (+2, +2) per tick. Idle cycles between ticks produce no movement.
- **Wall bounce:** force a state with y = 1 moving up → next tick y = 0, dy = down. Separately, from y = 471 moving down → y = 472, dy flips.
- **Hit and miss:**
  - `r_pos` = 208, ball at (606, 236) moving right → x = 608, dx = left.
  - `r_pos` = 0, ball at y = 236 → no bounce; when `x+10 > 640` the FSM passes through POINT, `l_score` = 1, the ball recentres, and the FSM returns to SERVE.
- **Win and reset:**
  - With `l_score` = 8, a left point → `l_score` = 9, `game_over` = 1, `winner` = 0, and frame ticks move nothing.
  - `serve` → scores cleared and IDLE.
  - `reset` asserted mid-PLAY → reset values in the same cycle.
